// File: rtl/epu_sram_pkg.sv
// Shared types and helpers for the EPU SRAM side blocks.
// Drain FSM states and a width helper that never returns zero.
package epu_sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } drain_state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// First-word-fall-through FIFO buffering tagged C-tile words.
// The head entry is visible combinationally whenever count is non-zero.
module drain_fifo
    import epu_sram_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = clog2_min1(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = clog2_min1(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= bump(wptr);
            end
            if (pop) begin
                rptr <= bump(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/c_tile_drain.sv
// Row-major read-out of the M x N C-tile SRAM onto a tagged valid/ready stream,
// with optional zeroing of each element once its read data has come back.
module c_tile_drain
    import epu_sram_pkg::*;
#(
    parameter int M             = 8,
    parameter int N             = 8,
    parameter int DATA_W        = 32,
    parameter int BYTE_W        = DATA_W / 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int CLEAR_ON_READ = 0,
    parameter int ROW_W         = clog2_min1(M),
    parameter int COL_W         = clog2_min1(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              c_en,
    output logic              c_re,
    output logic [ROW_W-1:0]  c_row,
    output logic [COL_W-1:0]  c_col,
    input  logic [DATA_W-1:0] c_rdata,
    input  logic              c_rvalid,
    output logic              c_we_en,
    output logic              c_we,
    output logic [ROW_W-1:0]  c_wrow,
    output logic [COL_W-1:0]  c_wcol,
    output logic [DATA_W-1:0] c_wdata,
    output logic [BYTE_W-1:0] c_wmask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic              out_last
);

    localparam int CNT_W   = clog2_min1(FIFO_DEPTH + 1);
    localparam int ENTRY_W = DATA_W + ROW_W + COL_W + 1;
    localparam bit CLEAR   = (CLEAR_ON_READ != 0);

    drain_state_t      state;
    drain_state_t      state_next;
    logic [ROW_W-1:0]  iss_row;
    logic [COL_W-1:0]  iss_col;
    logic [ROW_W-1:0]  ret_row;
    logic [COL_W-1:0]  ret_col;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic              credit;
    logic              issue;
    logic              accept;
    logic              pop;
    logic              iss_last;
    logic              ret_last;

    // Reads in flight plus buffered words never exceed the FIFO size,
    // so every returned word always has a slot waiting for it.
    assign credit = ({1'b0, inflight} + {1'b0, fifo_count})
                    < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue  = (state == RUN) && credit;
    assign accept = c_rvalid && ((state == RUN) || (state == DRAIN));
    assign pop    = out_valid && out_ready;

    assign iss_last = (iss_row == ROW_W'(M - 1)) && (iss_col == COL_W'(N - 1));
    assign ret_last = (ret_row == ROW_W'(M - 1)) && (ret_col == COL_W'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = RUN;
            end
            RUN: begin
                if (issue && iss_last) state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && out_last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_row  <= '0;
            iss_col  <= '0;
            ret_row  <= '0;
            ret_col  <= '0;
            inflight <= '0;
        end else if ((state == IDLE) && start) begin
            iss_row  <= '0;
            iss_col  <= '0;
            ret_row  <= '0;
            ret_col  <= '0;
            inflight <= '0;
        end else begin
            if (issue) begin
                if (iss_col == COL_W'(N - 1)) begin
                    iss_col <= '0;
                    iss_row <= (iss_row == ROW_W'(M - 1)) ? '0 : iss_row + ROW_W'(1);
                end else begin
                    iss_col <= iss_col + COL_W'(1);
                end
            end
            if (accept) begin
                if (ret_col == COL_W'(N - 1)) begin
                    ret_col <= '0;
                    ret_row <= (ret_row == ROW_W'(M - 1)) ? '0 : ret_row + ROW_W'(1);
                end else begin
                    ret_col <= ret_col + COL_W'(1);
                end
            end
            case ({issue, accept})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    drain_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   ({c_rdata, ret_row, ret_col, ret_last}),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign {out_data, out_row, out_col, out_last} = fifo_head;
    assign out_valid = (fifo_count != '0);

    assign c_en  = issue;
    assign c_re  = issue;
    assign c_row = iss_row;
    assign c_col = iss_col;

    // The element being cleared is the one whose data arrives this cycle.
    assign c_we    = CLEAR && accept;
    assign c_we_en = c_we;
    assign c_wrow  = c_we ? ret_row : '0;
    assign c_wcol  = c_we ? ret_col : '0;
    assign c_wdata = '0;
    assign c_wmask = '1;

endmodule

// File: tb/tb_c_tile_drain.sv
// Directed bench for c_tile_drain on an 8x8 tile with clear-on-read,
// driven by a behavioural in-order SRAM with selectable latency.
module tb_c_tile_drain;

    localparam int M  = 8;
    localparam int N  = 8;
    localparam int MN = M * N;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        c_en;
    logic        c_re;
    logic [2:0]  c_row;
    logic [2:0]  c_col;
    logic [31:0] c_rdata;
    logic        c_rvalid;
    logic        c_we_en;
    logic        c_we;
    logic [2:0]  c_wrow;
    logic [2:0]  c_wcol;
    logic [31:0] c_wdata;
    logic [3:0]  c_wmask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_row;
    logic [2:0]  out_col;
    logic        out_last;

    c_tile_drain #(
        .M             (M),
        .N             (N),
        .DATA_W        (32),
        .FIFO_DEPTH    (FD),
        .CLEAR_ON_READ (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .c_en      (c_en),
        .c_re      (c_re),
        .c_row     (c_row),
        .c_col     (c_col),
        .c_rdata   (c_rdata),
        .c_rvalid  (c_rvalid),
        .c_we_en   (c_we_en),
        .c_we      (c_we),
        .c_wrow    (c_wrow),
        .c_wcol    (c_wcol),
        .c_wdata   (c_wdata),
        .c_wmask   (c_wmask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t         q[$];
    logic [31:0] mem [MN];
    logic [31:0] rf  [MN];
    int          cyc = 0;
    int          s0 = 0;
    int          vecs = 0;
    int          errs = 0;
    int          beats, done_cnt, iss_cnt, we_cnt, maxq;
    int          first_cyc, last_cyc, done_cyc;
    logic        busy_at_done;
    bit          force_rv = 1'b0;
    int          lat_mode = 0;
    int          rdy_mode = 0;
    bit          holding = 1'b0;
    logic [63:0] held;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM return side: one in-order word per cycle once its latency expires.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            c_rvalid = 1'b0;
        end else if (force_rv) begin
            c_rvalid = 1'b1;
            c_rdata  = 32'hDEAD_BEEF;
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            c_rvalid = 1'b1;
            c_rdata  = q[0].data;
            void'(q.pop_front());
        end else begin
            c_rvalid = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = !((cyc - s0 >= 4) && (cyc - s0 <= 9));
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // Mid-cycle monitor: SRAM request side, clears, done and output beats.
    always @(negedge clk) begin
        logic [63:0] cur;
        logic [2:0]  er;
        logic [2:0]  ec;
        if (!rst) begin
            q.delete();
            holding = 1'b0;
        end else begin
            if (c_en) begin
                rd_t r;
                r.data = mem[int'(c_row) * N + int'(c_col)];
                r.due  = cyc + ((lat_mode != 0) ? int'($urandom_range(1, 3)) : 1);
                q.push_back(r);
                iss_cnt++;
                chk("re_pair", 64'(c_re), 64'd1);
            end
            if (q.size() > maxq) maxq = q.size();
            if (c_we) begin
                mem[int'(c_wrow) * N + int'(c_wcol)] = 32'd0;
                we_cnt++;
                chk("we_pair", 64'(c_we_en), 64'd1);
            end
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            cur = 64'({out_data, out_row, out_col, out_last});
            if (holding && out_valid) chk("hold", cur, held);
            holding = out_valid && !out_ready;
            held    = cur;
            if (out_valid && out_ready) begin
                if (beats >= MN) begin
                    chk("extra_beat", 64'(beats), 64'(MN - 1));
                end else begin
                    er = 3'(beats / N);
                    ec = 3'(beats % N);
                    chk("beat", cur,
                        64'({rf[beats], er, ec, beats == MN - 1}));
                end
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats++;
            end
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < MN; i++) begin
            mem[i] = (mode == 0) ? 32'(1000 + 10 * (i / N) + (i % N))
                                 : 32'(i * 37 + 5);
        end
    endtask

    task automatic begin_drain();
        for (int i = 0; i < MN; i++) rf[i] = mem[i];
        beats    = 0;
        done_cnt = 0;
        iss_cnt  = 0;
        we_cnt   = 0;
        maxq     = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        s0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", 64'(done_cnt > 0), 64'd1);
    endtask

    task automatic wait_cyc(input int rc);
        for (int i = 0; i < 400; i++) begin
            if (cyc >= s0 + rc) break;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive_start_at(input int rc);
        for (int i = 0; i < 400; i++) begin
            if (cyc == s0 + rc) break;
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, 64'({busy, done, c_en, c_re, c_we_en, c_we, out_valid}), 64'd0);
        chk({tag, "_addr"}, 64'({c_row, c_col, c_wrow, c_wcol}), 64'd0);
    endtask

    initial begin
        logic [63:0] sum;
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        c_rvalid  = 1'b0;
        c_rdata   = '0;
        fill(0);
        #3;
        chk_reset_outs("reset");
        chk("wmask", 64'(c_wmask), 64'hF);
        chk("wdata", 64'(c_wdata), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Nominal drain: 1-cycle SRAM, out_ready high, exact cycle timing.
        lat_mode = 0;
        rdy_mode = 0;
        begin_drain();
        wait_done(300);
        chk("first_beat_cyc", 64'(first_cyc - s0), 64'd3);
        chk("last_beat_cyc", 64'(last_cyc - s0), 64'(MN + 2));
        chk("done_cyc", 64'(done_cyc - s0), 64'(MN + 3));
        chk("busy_at_done", 64'(busy_at_done), 64'd1);
        wait_cyc(MN + 4);
        chk("busy_after", 64'(busy), 64'd0);
        chk("beats", 64'(beats), 64'(MN));
        chk("issues", 64'(iss_cnt), 64'(MN));
        chk("clears", 64'(we_cnt), 64'(MN));
        sum = 0;
        for (int i = 0; i < MN; i++) sum = sum + 64'(mem[i]);
        chk("mem_cleared", sum, 64'd0);

        // Second drain of the cleared tile must stream zeros.
        begin_drain();
        wait_done(300);
        chk("zero_beats", 64'(beats), 64'(MN));
        chk("zero_done", 64'(done_cnt), 64'd1);

        // Backpressure: out_ready low for cycles 4..9.
        fill(0);
        rdy_mode = 1;
        begin_drain();
        wait_cyc(9);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_head", 64'(out_data), 64'(rf[1]));
        chk("stall_issues", 64'(iss_cnt), 64'd5);
        wait_cyc(10);
        chk("no_issue_c10", 64'(iss_cnt), 64'd5);
        wait_cyc(11);
        chk("resume_c11", 64'(iss_cnt), 64'd6);
        wait_done(400);
        chk("bp_beats", 64'(beats), 64'(MN));
        chk("bp_done", 64'(done_cnt), 64'd1);

        // Variable latency and random out_ready.
        fill(1);
        lat_mode = 1;
        rdy_mode = 2;
        begin_drain();
        wait_done(2000);
        chk("rnd_beats", 64'(beats), 64'(MN));
        chk("rnd_maxq", 64'(maxq <= FD), 64'd1);
        chk("rnd_done", 64'(done_cnt), 64'd1);

        // Stray rvalid in IDLE, then start re-pulsed mid-drain and in DONE.
        lat_mode = 0;
        rdy_mode = 0;
        fill(0);
        we_cnt = 0;
        @(negedge clk);
        force_rv = 1'b1;
        repeat (2) @(negedge clk);
        force_rv = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_rv_valid", 64'(out_valid), 64'd0);
        chk("idle_rv_clear", 64'(we_cnt), 64'd0);
        chk("idle_rv_busy", 64'(busy), 64'd0);
        begin_drain();
        drive_start_at(20);
        drive_start_at(MN + 3);
        wait_done(300);
        wait_cyc(MN + 4);
        chk("restart_busy", 64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        #1;
        chk("single_done", 64'(done_cnt), 64'd1);
        chk("ign_beats", 64'(beats), 64'(MN));
        chk("ign_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset at element 20, then a full fresh drain.
        fill(1);
        lat_mode = 1;
        begin_drain();
        for (int i = 0; i < 400; i++) begin
            if (beats >= 20) break;
            @(negedge clk);
            #1;
        end
        chk("reached_20", 64'(beats >= 20), 64'd1);
        rst = 1'b0;
        #1;
        chk_reset_outs("mid_reset");
        repeat (2) @(negedge clk);
        chk("no_done_reset", 64'(done_cnt), 64'd0);
        rst = 1'b1;
        fill(0);
        begin_drain();
        wait_done(2000);
        chk("post_rst_beats", 64'(beats), 64'(MN));
        chk("post_rst_done", 64'(done_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/c_tile_drain.md
# c_tile_drain

Read-side initiator for the M×N C-tile SRAM (`sram_mem_mn_c`).
- On a start pulse it walks the tile in row-major order and issues one read per element on the SRAM read port (`c_en`/`c_re`/`c_row`/`c_col`).
- It collects returned words on `c_rvalid` and streams them out on a valid/ready interface tagged with row, column and last.
- It can optionally zero each element on the SRAM write port once the element has been read.
- It sits between the EPU accumulation array's C buffer and the result writeback path.

## Interface
Parameters:
- M, 8, tile rows
- N, 8, tile columns
- DATA_W, 32, word width
- BYTE_W, DATA_W/8, write-mask width
- FIFO_DEPTH, 4, output buffer entries; also the cap on reads in flight plus buffered words; minimum 2
- CLEAR_ON_READ, 0, 1 = write zero to each element after its read data returns
- ROW_W, (M<=1)?1:$clog2(M), row index width
- COL_W, (N<=1)?1:$clog2(N), column index width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request to drain the whole tile; ignored while busy
- busy  out  1  high from the cycle after accepted start until the done cycle inclusive
- done  out  1  one-cycle pulse after the final output handshake
- c_en, c_re  out  1 each  read request; both driven identically
- c_row, c_col  out  ROW_W, COL_W  read address
- c_rdata  in  DATA_W  read data
- c_rvalid  in  1  read data valid
- c_we_en, c_we  out  1 each  clear write; both driven identically
- c_wrow, c_wcol  out  ROW_W, COL_W  clear address
- c_wdata  out  DATA_W  constant 0
- c_wmask  out  BYTE_W  constant all-ones
- out_valid, out_ready  out/in  1 each  output handshake
- out_data  out  DATA_W  element value
- out_row, out_col  out  ROW_W, COL_W  element coordinates
- out_last  out  1  high on element (M-1,N-1)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start -> RUN; clear the issue, return and emit counters.
  - RUN: issue a read when inflight + fifo_count < FIFO_DEPTH. Advance the issue (row,col) row-major: col wraps at N-1 and increments row. After issuing (M-1,N-1) -> DRAIN.
  - DRAIN: no new reads. When the final element is handshaked (out_valid && out_ready && out_last) -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- SRAM contract: exactly one `c_rvalid` per read, returned in issue order. The block counts returns and does not rely on a fixed latency.
- inflight:
  - +1 on issue; −1 on `c_rvalid`; both in the same cycle leaves it unchanged.
  - Width is $clog2(FIFO_DEPTH+1).
- Returned word is pushed into the FIFO. The return counter (ret_row, ret_col) tags it. The FIFO never overflows because of the credit rule.
- Clear (CLEAR_ON_READ=1):
  - In the cycle `c_rvalid` is high, drive `c_we_en`=`c_we`=1 with `c_wrow`/`c_wcol` = ret_row/ret_col.
  - A clear never targets an address with a read still pending.
  - With CLEAR_ON_READ=0 the write port is held idle.
- `c_rvalid` seen in IDLE or DONE is ignored: no push, no clear.
- Output: out_* show the FIFO head. A pop happens on out_valid && out_ready. Data and tags are held stable while out_valid && !out_ready.

## Timing
- Reset values (rst low, async): state IDLE, busy=0, done=0, c_en=c_re=0, c_we_en=c_we=0, out_valid=0, all counters/FIFO empty, address outputs 0.
- Reset mid-operation aborts the drain immediately. No done pulse is produced.
- With 1-cycle SRAM latency and out_ready held high:
  - start at cycle 0; first read at cycle 1; `c_rvalid` at 2; first out_valid at 3.
  - One element per cycle; last element at cycle M*N+2; done at M*N+3; busy low at M*N+4.
- Backpressure: with out_ready low, at most FIFO_DEPTH reads are outstanding or buffered. Issue resumes the cycle after a pop frees a credit.
- start during busy is dropped. start in the DONE cycle is dropped.
- M=N=1: a single read; RUN -> DRAIN immediately after that issue; out_last on the only element.

## Structure
- Shared package `epu_sram_pkg`:
  - drain_state_t enum (IDLE, RUN, DRAIN, DONE)
  - clog2-with-min-1 helper function for ROW_W/COL_W/count widths
- Sub-module `drain_fifo`: synchronous FIFO, FIFO_DEPTH entries of {DATA_W data, ROW_W row, COL_W col, last}.
  - Signals: push/pop/count; first-word-fall-through head.
  - Reset is asynchronous active-low.
- Top-level: FSM, issue/return counters, inflight counter, clear-write drive.

## Test plan
- M=2, N=3, SRAM preloaded with value = 10*row+col, out_ready=1, start at cycle 0 -> six beats at cycles 3..8: 0,1,2,10,11,12 with matching row/col. out_last only on 12. done at cycle 9.
- Same tile, out_ready low cycles 4–9 -> reads stop after FIFO_DEPTH credits; out_data stays 1 while stalled; sequence completes unchanged with no lost or duplicated beats.
- CLEAR_ON_READ=1, M=N=8 with non-zero data -> 64 beats emitted with original values; a second drain then returns 64 zeros.
- SRAM model with variable 1–3 cycle latency, random out_ready -> output order and values match row-major reference. inflight never exceeds FIFO_DEPTH.
- start pulsed again mid-drain, and `c_rvalid` forced in IDLE -> both ignored; exactly one done; no FIFO push.
- rst asserted at element 20 of 64 -> all outputs drop to reset values asynchronously. A new start then gives a full, correct 64-beat drain.
